// File: rtl/controle_medida_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 measurement sequencer.
// Holds the state codes and the default timing constants for a 50 MHz clock.
package controle_medida_hcsr04_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREPARA   = 4'd1,
    TRIGGER   = 4'd2,
    ESPERA    = 4'd3,
    MEDE      = 4'd4,
    ARMAZENA  = 4'd5,
    FIM       = 4'd6,
    ERRO      = 4'd7,
    INTERVALO = 4'd8
  } estado_t;

  localparam int T_TRIG_PADRAO = 500;
  localparam int T_TOUT_PADRAO = 1_500_000;
  localparam int T_PER_PADRAO  = 5_000_000;
  localparam int W_PADRAO      = 23;

endpackage

// File: rtl/controle_medida_hcsr04_temporizador.sv
// Saturating cycle counter with synchronous clear.
// tc is high while the count sits at the limit; the count never wraps.
module temporizador_ciclos #(
  parameter int W = 23
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limite,
  output logic         tc
);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (clear) begin
      contagem <= '0;
    end else if (enable && (contagem < limite)) begin
      contagem <= contagem + W'(1);
    end
  end

  assign tc = (contagem >= limite);

endmodule

// File: rtl/controle_medida_hcsr04.sv
// HC-SR04 measurement sequencer: clears the cm counter, pulses trigger, waits for echo
// with timeouts and latches the three BCD digits; single-shot or periodic operation.
module controle_medida_hcsr04
  import controle_medida_hcsr04_pkg::*;
#(
  parameter int T_TRIG = T_TRIG_PADRAO,
  parameter int T_TOUT = T_TOUT_PADRAO,
  parameter int T_PER  = T_PER_PADRAO,
  parameter int W      = W_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        continuo,
  input  logic        echo,
  input  logic        pronto_cm,
  input  logic [3:0]  dig0_cm,
  input  logic [3:0]  dig1_cm,
  input  logic [3:0]  dig2_cm,
  output logic        trigger,
  output logic        zera_cm,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam logic [W-1:0] LIM_TRIG = W'(T_TRIG - 1);
  localparam logic [W-1:0] LIM_TOUT = W'(T_TOUT - 1);
  localparam logic [W-1:0] LIM_PER  = W'(T_PER - 1);

  estado_t      estado;
  estado_t      proximo;
  logic [W-1:0] limite_fase;
  logic         fase_tc;
  logic         periodo_tc;
  logic         muda_estado;
  logic         inicia_periodo;

  assign muda_estado = (proximo != estado);
  assign limite_fase = (estado == TRIGGER) ? LIM_TRIG : LIM_TOUT;
  // The period count starts in the PREPARA cycle, so trigger rises land exactly T_PER apart.
  assign inicia_periodo = (proximo == PREPARA);

  temporizador_ciclos #(.W(W)) u_fase (
    .clock  (clock),
    .reset  (reset),
    .clear  (muda_estado),
    .enable (1'b1),
    .limite (limite_fase),
    .tc     (fase_tc)
  );

  temporizador_ciclos #(.W(W)) u_periodo (
    .clock  (clock),
    .reset  (reset),
    .clear  (inicia_periodo),
    .enable (1'b1),
    .limite (LIM_PER),
    .tc     (periodo_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= IDLE;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = IDLE;
    case (estado)
      IDLE:      proximo = medir ? PREPARA : IDLE;
      PREPARA:   proximo = TRIGGER;
      TRIGGER:   proximo = fase_tc ? ESPERA : TRIGGER;
      ESPERA: begin
        if (echo)         proximo = MEDE;
        else if (fase_tc) proximo = ERRO;
        else              proximo = ESPERA;
      end
      // A done pulse on the timeout cycle still counts as a valid measurement.
      MEDE: begin
        if (pronto_cm)    proximo = ARMAZENA;
        else if (fase_tc) proximo = ERRO;
        else              proximo = MEDE;
      end
      ARMAZENA:  proximo = FIM;
      FIM:       proximo = continuo ? INTERVALO : IDLE;
      ERRO:      proximo = continuo ? INTERVALO : IDLE;
      INTERVALO: begin
        if (!continuo)       proximo = IDLE;
        else if (periodo_tc) proximo = PREPARA;
        else                 proximo = INTERVALO;
      end
      default:   proximo = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigger <= 1'b0;
      zera_cm <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
      medida  <= 12'h000;
    end else begin
      trigger <= (proximo == TRIGGER);
      zera_cm <= (proximo == PREPARA);
      pronto  <= (proximo == FIM);
      if (proximo == PREPARA) begin
        erro <= 1'b0;
      end else if (proximo == ERRO) begin
        erro <= 1'b1;
      end
      if (estado == ARMAZENA) begin
        medida <= {dig2_cm, dig1_cm, dig0_cm};
      end
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_controle_medida_hcsr04.sv
// Self-checking bench for controle_medida_hcsr04 with short timing constants.
// Table of cycle-stepped vectors plus hand sequences for periodic mode and reset.
module tb_controle_medida_hcsr04;
  import controle_medida_hcsr04_pkg::*;

  localparam int T_TRIG = 5;
  localparam int T_TOUT = 50;
  localparam int T_PER  = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        continuo = 1'b0;
  logic        echo = 1'b0;
  logic        pronto_cm = 1'b0;
  logic [11:0] digitos = 12'h000;
  logic        trigger;
  logic        zera_cm;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int total = 0;
  int bad = 0;
  int ciclo = 0;

  // Expected word: {estado[3:0], trigger, zera_cm, pronto, erro, medida[11:0]}
  typedef struct {
    logic        medir;
    logic        continuo;
    logic        echo;
    logic        pronto_cm;
    logic [11:0] dig;
    int          ciclos;
    logic [19:0] esperado;
  } vetor_t;

  vetor_t tab[$];

  controle_medida_hcsr04 #(
    .T_TRIG (T_TRIG),
    .T_TOUT (T_TOUT),
    .T_PER  (T_PER),
    .W      (23)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .medir     (medir),
    .continuo  (continuo),
    .echo      (echo),
    .pronto_cm (pronto_cm),
    .dig0_cm   (digitos[3:0]),
    .dig1_cm   (digitos[7:4]),
    .dig2_cm   (digitos[11:8]),
    .trigger   (trigger),
    .zera_cm   (zera_cm),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  function automatic logic [19:0] observado();
    return {db_estado, trigger, zera_cm, pronto, erro, medida};
  endfunction

  task automatic add_vec(input logic m, input logic c, input logic e, input logic p,
                         input logic [11:0] d, input int n, input logic [3:0] est,
                         input logic tr, input logic z, input logic pr, input logic er,
                         input logic [11:0] med);
    vetor_t v;
    v.medir = m;
    v.continuo = c;
    v.echo = e;
    v.pronto_cm = p;
    v.dig = d;
    v.ciclos = n;
    v.esperado = {est, tr, z, pr, er, med};
    tab.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input vetor_t v);
    medir = v.medir;
    continuo = v.continuo;
    echo = v.echo;
    pronto_cm = v.pronto_cm;
    digitos = v.dig;
  endtask

  task automatic check_output(input string nome, input logic [19:0] atual,
                              input logic [19:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (estado,trig,zera,pronto,erro,medida)",
               nome, atual, esperado);
    end
  endtask

  task automatic wait_trigger(input logic valor, input int limite);
    int n = 0;
    while (trigger !== valor && n < limite) begin
      tick();
      n++;
    end
    check_output(valor ? "trigger_rise" : "trigger_fall", 20'(trigger), 20'(valor));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int subida[3];
    logic [11:0] dig_cont[3];
    logic viu_trigger;

    dig_cont[0] = 12'h789;
    dig_cont[1] = 12'h321;
    dig_cont[2] = 12'h905;

    // good measurement, digits 1,2,3
    add_vec(1, 0, 0, 0, 12'h000,  1, 4'd1, 0, 1, 0, 0, 12'h000);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd2, 1, 0, 0, 0, 12'h000);
    add_vec(0, 0, 0, 0, 12'h000,  4, 4'd2, 1, 0, 0, 0, 12'h000);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd3, 0, 0, 0, 0, 12'h000);
    add_vec(0, 0, 0, 0, 12'h000,  3, 4'd3, 0, 0, 0, 0, 12'h000);
    add_vec(0, 0, 1, 0, 12'h000,  1, 4'd4, 0, 0, 0, 0, 12'h000);
    add_vec(0, 0, 1, 0, 12'h000, 19, 4'd4, 0, 0, 0, 0, 12'h000);
    add_vec(0, 0, 0, 1, 12'h123,  1, 4'd5, 0, 0, 0, 0, 12'h000);
    add_vec(0, 0, 0, 0, 12'h123,  1, 4'd6, 0, 0, 1, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h123,  1, 4'd0, 0, 0, 0, 0, 12'h123);
    // echo never rises: 50 cycles in ESPERA then ERRO
    add_vec(1, 0, 0, 0, 12'h000,  1, 4'd1, 0, 1, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd2, 1, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  5, 4'd3, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000, 48, 4'd3, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd3, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd7, 0, 0, 0, 1, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd0, 0, 0, 0, 1, 12'h123);
    // echo already high at ESPERA entry, no pronto_cm: 50 cycles in MEDE then ERRO
    add_vec(1, 0, 0, 0, 12'h000,  1, 4'd1, 0, 1, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000,  1, 4'd2, 1, 0, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000,  5, 4'd3, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000,  1, 4'd4, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000, 49, 4'd4, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000,  1, 4'd7, 0, 0, 0, 1, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd0, 0, 0, 0, 1, 12'h123);
    // good measurement with pronto_cm on the timeout cycle, clears erro
    add_vec(1, 0, 0, 0, 12'h000,  1, 4'd1, 0, 1, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  1, 4'd2, 1, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000,  5, 4'd3, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 1, 0, 12'h000,  1, 4'd4, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h000, 49, 4'd4, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 1, 12'h456,  1, 4'd5, 0, 0, 0, 0, 12'h123);
    add_vec(0, 0, 0, 0, 12'h456,  1, 4'd6, 0, 0, 1, 0, 12'h456);
    add_vec(0, 0, 0, 0, 12'h456,  1, 4'd0, 0, 0, 0, 0, 12'h456);

    repeat (3) tick();
    check_output("reset_state", observado(), 20'h00000);
    reset = 1'b1;
    tick();
    check_output("after_reset", observado(), 20'h00000);

    for (int i = 0; i < tab.size(); i++) begin
      apply_stimulus(tab[i]);
      repeat (tab[i].ciclos) tick();
      check_output($sformatf("vec%0d", i), observado(), tab[i].esperado);
    end

    // periodic mode: three measurements, trigger rises T_PER apart
    $display("[TB] periodic mode");
    medir = 1'b1;
    continuo = 1'b1;
    tick();
    medir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_trigger(1'b1, 300);
      subida[i] = ciclo;
      wait_trigger(1'b0, 20);
      repeat (2) tick();
      echo = 1'b1;
      repeat (20) tick();
      echo = 1'b0;
      pronto_cm = 1'b1;
      digitos = dig_cont[i];
      tick();
      pronto_cm = 1'b0;
      tick();
      check_output($sformatf("cont_fim%0d", i), observado(),
                   {4'd6, 1'b0, 1'b0, 1'b1, 1'b0, dig_cont[i]});
      tick();
      check_output($sformatf("cont_intervalo%0d", i), observado(),
                   {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, dig_cont[i]});
    end
    check_output("periodo_1", 20'(subida[1] - subida[0]), 20'(T_PER));
    check_output("periodo_2", 20'(subida[2] - subida[1]), 20'(T_PER));

    // dropping continuo during INTERVALO returns to IDLE at once
    repeat (10) tick();
    check_output("intervalo_hold", 20'(db_estado), 20'(4'd8));
    continuo = 1'b0;
    tick();
    check_output("continuo_drop", observado(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h905});
    viu_trigger = 1'b0;
    for (int k = 0; k < 250; k++) begin
      tick();
      if (trigger) viu_trigger = 1'b1;
    end
    check_output("no_more_trigger", 20'(viu_trigger), 20'h00000);

    // reset asserted while the trigger pulse is high
    $display("[TB] reset during trigger");
    medir = 1'b1;
    tick();
    medir = 1'b0;
    tick();
    tick();
    check_output("pre_reset_trigger", observado(), {4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h905});
    #3;
    reset = 1'b0;
    #1;
    check_output("async_reset", observado(), 20'h00000);
    tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
    check_output("post_reset_idle", observado(), 20'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
